// File: rtl/log_pkg.sv
`default_nettype none
// ============================================================================
// Module      : log_pkg
// Description : Shared opcodes, flag and entry types for the logic-unit result
//               path. LOG_RESULT_STAGE_PARITY_EN adds a parity flag.
// Revision    : 1.0 - initial release
// ============================================================================
package log_pkg;

  localparam int LOG_DATA_W = 16;
  localparam int LOG_SEL_W  = 4;

  typedef enum logic [LOG_SEL_W-1:0] {
    LOG_NOT_A      = 4'b0000,
    LOG_NOR        = 4'b0001,
    LOG_NOTA_AND_B = 4'b0010,
    LOG_ZERO       = 4'b0011,
    LOG_NAND       = 4'b0100,
    LOG_NOT_B      = 4'b0101,
    LOG_XOR        = 4'b0110,
    LOG_A_AND_NOTB = 4'b0111,
    LOG_NOTA_OR_B  = 4'b1000,
    LOG_XNOR       = 4'b1001,
    LOG_PASS_B     = 4'b1010,
    LOG_AND        = 4'b1011,
    LOG_ONE        = 4'b1100,
    LOG_A_OR_NOTB  = 4'b1101,
    LOG_OR         = 4'b1110,
    LOG_PASS_A     = 4'b1111
  } log_op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic cmp;
`ifdef LOG_RESULT_STAGE_PARITY_EN
    logic par;
`endif
  } log_flags_t;

  typedef struct packed {
    logic [LOG_DATA_W-1:0] res;
    logic [LOG_SEL_W-1:0]  sel;
    log_flags_t            flags;
  } log_entry_t;

  // Opcodes whose result is a constant regardless of the operands.
  function automatic logic is_const_op(input logic [LOG_SEL_W-1:0] sel);
    return (sel == LOG_ZERO) || (sel == LOG_ONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/log_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : log_skid_buf
// Description : Two-entry skid buffer over log_entry_t; registered in_ready,
//               full throughput, strict FIFO order.
// Revision    : 1.0 - initial release
// ============================================================================
module log_skid_buf
  import log_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  log_entry_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output log_entry_t out_data
);

  log_entry_t r_main;
  log_entry_t r_skid;
  logic       r_main_v;
  logic       r_skid_v;

  logic w_in_xfer;
  logic w_main_free;

  assign w_in_xfer   = in_valid && !r_skid_v;
  // Main may take new data when it is empty or being consumed this cycle.
  assign w_main_free = !r_main_v || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else if (w_in_xfer) begin
        r_main   <= in_data;
        r_main_v <= 1'b1;
      end else begin
        r_main_v <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skid   <= in_data;
      r_skid_v <= 1'b1;
    end
  end

  assign in_ready  = !r_skid_v;
  assign out_valid = r_main_v;
  assign out_data  = r_main;

endmodule
`default_nettype wire

// File: rtl/log_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : log_result_stage
// Description : Registered result/flag stage behind the 16-bit logic unit with
//               valid/ready handshake and saturating accepted-result counter.
//               Define LOG_RESULT_STAGE_PARITY_EN to add the out_par output.
// Revision    : 1.0 - initial release
// ============================================================================
module log_result_stage
  import log_pkg::*;
#(
  parameter int DATA_W = LOG_DATA_W,
  parameter int SEL_W  = LOG_SEL_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_res,
  input  logic [SEL_W-1:0]  in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_cmp,
`ifdef LOG_RESULT_STAGE_PARITY_EN
  output logic              out_par,
`endif
  output logic [CNT_W-1:0]  acc_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  log_entry_t       w_entry_in;
  log_entry_t       w_entry_out;
  logic             w_in_ready;
  logic [CNT_W-1:0] r_acc_cnt;

  // Flags are fixed at capture time and travel with the entry.
  always_comb begin
    w_entry_in            = '0;
    w_entry_in.res        = in_res;
    w_entry_in.sel        = in_sel;
    w_entry_in.flags.zero = (in_res == '0);
    w_entry_in.flags.neg  = in_res[DATA_W-1];
    w_entry_in.flags.cmp  = is_const_op(in_sel);
`ifdef LOG_RESULT_STAGE_PARITY_EN
    w_entry_in.flags.par  = ^in_res;
`endif
  end

  log_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_entry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_entry_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_cnt <= '0;
    end else if (in_valid && w_in_ready && (r_acc_cnt != c_cnt_max)) begin
      r_acc_cnt <= r_acc_cnt + CNT_W'(1);
    end
  end

  assign in_ready = w_in_ready;
  assign out_res  = w_entry_out.res;
  assign out_sel  = w_entry_out.sel;
  assign out_zero = w_entry_out.flags.zero;
  assign out_neg  = w_entry_out.flags.neg;
  assign out_cmp  = w_entry_out.flags.cmp;
`ifdef LOG_RESULT_STAGE_PARITY_EN
  assign out_par  = w_entry_out.flags.par;
`endif
  assign acc_cnt  = r_acc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_log_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_log_result_stage
// Description : Directed self-checking bench for log_result_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_log_result_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_res;
  logic [3:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic [3:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
  logic        out_cmp;
`ifdef LOG_RESULT_STAGE_PARITY_EN
  logic        out_par;
`endif
  logic [7:0]  acc_cnt;

  int n_vec;
  int n_err;

  log_result_stage #(.DATA_W(16), .SEL_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_sel   (out_sel),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_cmp   (out_cmp),
`ifdef LOG_RESULT_STAGE_PARITY_EN
    .out_par   (out_par),
`endif
    .acc_cnt   (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] res, input logic [3:0] sel);
    in_valid = v;
    in_res   = res;
    in_sel   = sel;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_res"},   32'(out_res),   32'd0);
    check({tag, "_out_sel"},   32'(out_sel),   32'd0);
    check({tag, "_flags"},     32'({out_zero, out_neg, out_cmp}), 32'd0);
    check({tag, "_acc_cnt"},   32'(acc_cnt),   32'd0);
`ifdef LOG_RESULT_STAGE_PARITY_EN
    check({tag, "_out_par"},   32'(out_par),   32'd0);
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 16'h0, 4'h0);
    tick();
    tick();
    check_reset_state("rst");
    rst = 1'b0;
    tick();
    check_reset_state("post_rst");

    // Single transfer of a constant-producing opcode with zero result.
    out_ready = 1'b1;
    drive(1'b1, 16'h0000, 4'b0011);
    tick();
    drive(1'b0, 16'h0, 4'h0);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_zero",  32'(out_zero),  32'd1);
    check("single_cmp",   32'(out_cmp),   32'd1);
    check("single_neg",   32'(out_neg),   32'd0);
    check("single_sel",   32'(out_sel),   32'h3);
    check("single_cnt",   32'(acc_cnt),   32'd1);
    tick();
    check("single_drain", 32'(out_valid), 32'd0);

    // Back-pressure: fill main and skid.
    out_ready = 1'b0;
    drive(1'b1, 16'h8001, 4'h5);
    tick();
    check("bp_rdy1", 32'(in_ready), 32'd1);
    drive(1'b1, 16'h1234, 4'hC);
    tick();
    drive(1'b0, 16'h0, 4'h0);
    check("bp_rdy2",  32'(in_ready),  32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_res",   32'(out_res),   32'h8001);
    check("bp_neg",   32'(out_neg),   32'd1);
    check("bp_cmp",   32'(out_cmp),   32'd0);
    check("bp_cnt",   32'(acc_cnt),   32'd3);
`ifdef LOG_RESULT_STAGE_PARITY_EN
    check("bp_par",   32'(out_par),   32'd0);
`endif
    tick();
    check("bp_hold_res", 32'(out_res), 32'h8001);
    check("bp_hold_rdy", 32'(in_ready), 32'd0);

    // One-cycle out_ready pulse: skid entry moves to main.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pulse_valid", 32'(out_valid), 32'd1);
    check("pulse_res",   32'(out_res),   32'h1234);
    check("pulse_sel",   32'(out_sel),   32'hC);
    check("pulse_cmp",   32'(out_cmp),   32'd1);
    check("pulse_neg",   32'(out_neg),   32'd0);
    check("pulse_rdy",   32'(in_ready),  32'd1);
    tick();
    check("pulse_hold", 32'(out_res), 32'h1234);
    out_ready = 1'b1;
    tick();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Full throughput: 100 back-to-back transfers, 1-cycle latency.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 4'(i));
      tick();
      check("thru_valid", 32'(out_valid), 32'd1);
      check("thru_res",   32'(out_res),   32'(16'h0100 + i));
      check("thru_rdy",   32'(in_ready),  32'd1);
    end
    check("thru_cnt", 32'(acc_cnt), 32'd103);

    // Saturation of the accepted-result counter.
    for (int i = 0; i < 151; i++) begin
      drive(1'b1, 16'(i), 4'h6);
      tick();
    end
    check("sat_fe", 32'(acc_cnt), 32'hFE);
    tick();
    check("sat_ff", 32'(acc_cnt), 32'hFF);
    for (int i = 0; i < 50; i++) tick();
    check("sat_hold", 32'(acc_cnt), 32'hFF);
    drive(1'b0, 16'h0, 4'h0);
    tick();
    check("sat_drain", 32'(out_valid), 32'd0);

    // Reset with both entries occupied and handshakes in flight.
    out_ready = 1'b0;
    drive(1'b1, 16'h5555, 4'h6);
    tick();
    drive(1'b1, 16'h00AA, 4'h9);
    tick();
    check("mid_full_rdy", 32'(in_ready), 32'd0);
    check("mid_full_res", 32'(out_res),  32'h5555);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 16'h0, 4'h0);
    check_reset_state("mid_rst");
    tick();
    check("mid_idle_valid", 32'(out_valid), 32'd0);

    out_ready = 1'b1;
    drive(1'b1, 16'h0007, 4'hF);
    tick();
    drive(1'b0, 16'h0, 4'h0);
    check("p7_valid", 32'(out_valid), 32'd1);
    check("p7_res",   32'(out_res),   32'h0007);
    check("p7_sel",   32'(out_sel),   32'hF);
    check("p7_zero",  32'(out_zero),  32'd0);
    check("p7_cnt",   32'(acc_cnt),   32'd1);
`ifdef LOG_RESULT_STAGE_PARITY_EN
    check("p7_par",   32'(out_par),   32'd1);
`endif
    tick();
    check("p7_drain", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/log_result_stage.md
Name: log_result_stage

Overview:
- Registered output stage directly downstream of the 16-bit logic unit.
- Captures the logic result `lout` and the 4-bit opcode `sel` that produced it, and derives status flags.
- Presents result and flags to the writeback/consumer through a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with registered `in_ready`.
- A saturating counter tracks the number of accepted results.

Parameters:
- DATA_W, 16, width of result path (matches logic unit)
- SEL_W, 4, width of opcode field
- CNT_W, 8, width of accepted-result counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept a result
- in_res  input  DATA_W  result from logic unit (lout)
- in_sel  input  SEL_W  opcode that produced in_res
- out_valid  output  1  result available to consumer
- out_ready  input  1  consumer accepts result
- out_res  output  DATA_W  buffered result
- out_sel  output  SEL_W  buffered opcode
- out_zero  output  1  out_res == 0
- out_neg  output  1  out_res[DATA_W-1]
- out_cmp  output  1  high when out_sel is a constant-producing opcode (4'b0011 or 4'b1100)
- acc_cnt  output  CNT_W  saturating count of accepted input transfers

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Storage: a main register (drives outputs) and a skid register, each holding {res, sel, zero, neg, cmp, valid}.
- Flags: zero, neg and cmp are computed combinationally from in_res/in_sel at capture and stored alongside; never recomputed from stored data.
- in_ready: driven from a register, equal to !skid_valid.
- Latency: 1 cycle from input transfer to out_valid when main is empty or draining.
- Capture rules:
  - Main empty, or main draining this cycle with skid empty: input loads main.
  - Main full and not draining, skid empty: input loads skid; in_ready drops next cycle.
  - Main draining with skid full: skid moves to main. No input is accepted, since in_ready=0.
- Ordering: strict FIFO; data is never dropped or duplicated.
- Simultaneous transfers: input and output transfers in the same cycle are both honoured.
- Holding:
  - out_valid with !out_ready: out_res/out_sel/flags are held stable.
  - out_valid never deasserts without a transfer.
- acc_cnt:
  - Increments on each input transfer.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset:
  - Values: out_valid=0, in_ready=1 (on the first cycle after rst deasserts), out_res=0, out_sel=0, all flags 0, acc_cnt=0, skid empty.
  - Reset asserted mid-transfer discards both buffered entries; in-flight handshakes that cycle are ignored.
- in_res/in_sel are don't-care when in_valid=0.

Optional Feature:
- Macro: LOG_RESULT_STAGE_PARITY_EN
- Defined:
  - Adds output out_par (1 bit) = even parity (XOR-reduce) of out_res.
  - Computed at capture and stored with the entry like other flags.
  - Reset value 0.
- Undefined: the port and its storage are absent. All other behaviour is identical.

Decomposition:
- Shared package log_pkg:
  - typedef enum for the 16 logic opcodes (LOG_NOT_A=4'b0000 … LOG_PASS_A=4'b1111), including LOG_ZERO=4'b0011 and LOG_ONE=4'b1100 used by cmp.
  - Packed struct log_flags_t {zero, neg, cmp[, par]}.
  - Packed struct log_entry_t {res, sel, flags}.
  - DATA_W/SEL_W default constants.
- Sub-module: log_skid_buf, a generic 2-entry skid buffer over log_entry_t.
- Top level holds the flag derivation and acc_cnt.

Test Plan:
- Reset then single transfer:
  - Stimulus: in_res=16'h0000, in_sel=4'b0011, out_ready=1.
  - Response: next cycle out_valid=1, out_zero=1, out_cmp=1, out_neg=0; acc_cnt=1.
- Back-pressure:
  - Stimulus: out_ready=0; send 16'h8001 then 16'h1234.
  - Response: in_ready=0 after the second transfer; out_res holds 16'h8001 with out_neg=1. Raising out_ready yields 16'h8001 then 16'h1234 on consecutive cycles.
- Full throughput:
  - Stimulus: in_valid and out_ready held 1 for 100 cycles with incrementing data.
  - Response: 100 outputs in order, 1-cycle latency, in_ready constantly 1.
- Simultaneous events:
  - Stimulus: main full, skid full, out_ready pulses for one cycle.
  - Response: skid entry moves to main; in_ready returns to 1 the next cycle; no loss.
- Saturation:
  - Stimulus: 300 accepted transfers with CNT_W=8.
  - Response: acc_cnt stops at 8'hFF.
- Reset mid-operation:
  - Stimulus: both entries full, rst asserted one cycle.
  - Response: out_valid=0, acc_cnt=0, in_ready=1 on the first cycle after rst deasserts; with the macro defined, out_par=0 and a later 16'h0007 gives out_par=1.
